// File: rtl/marin_uart_pkg.sv
// Shared definitions for the Marin UART transmitter: register offsets,
// status bit positions, transmitter state encoding and divisor floor.
// Optional macro UART_TX_PARITY_EN adds the PARITY state.
package marin_uart_pkg;

   // Register select, taken from wb_adr_i[1]
   localparam logic REG_DATA = 1'b0;
   localparam logic REG_DIV  = 1'b1;

   // STATUS word bit positions
   localparam int ST_FULL  = 0;
   localparam int ST_EMPTY = 1;
   localparam int ST_BUSY  = 2;
   localparam int ST_OVF   = 3;

   // Smallest divisor the bit timer can honour
   localparam logic [15:0] MIN_DIV = 16'd2;

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } tx_state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } tx_state_t;
`endif

   // Divisors below the floor are silently raised to it
   function automatic logic [15:0] clamp_div(input logic [15:0] value);
      return (value < MIN_DIV) ? MIN_DIV : value;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the transmitter. Pushes into a full FIFO and pops
// from an empty one are ignored; full/empty/count reflect the current
// (pre-edge) occupancy so callers can decide on it within the cycle.
module uart_tx_fifo #(
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push,
   input  logic [7:0]    din,
   input  logic          pop,
   output logic [7:0]    dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   logic [7:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   count_reg;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   // Head of queue is visible without a read cycle so the transmitter
   // can load it on the same edge it pops
   assign dout    = mem[rd_ptr_reg];

   // Storage array, written only on accepted pushes
   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         if (push_ok && !pop_ok) begin
            count_reg <= count_reg + (AW+1)'(1);
         end else if (pop_ok && !push_ok) begin
            count_reg <= count_reg - (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/uart_tx_wb.sv
// 16-bit Wishbone UART transmitter: DATA pushes bytes into a FIFO,
// STATUS reports FIFO/transmitter state, DIV sets clocks per bit.
// Optional macro UART_TX_PARITY_EN appends an even-parity bit (8E1).
module uart_tx_wb
   import marin_uart_pkg::*;
#(
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [15:0] wb_dat_i,
   output logic [15:0] wb_dat_o,
   input  logic [31:0] wb_adr_i,
   input  logic [1:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   output logic        wb_ack_o,
   output logic        tx_o
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   // Bus side
   logic        ack_reg;
   logic [15:0] dat_o_reg;
   logic        ovf_reg;
   logic [15:0] div_reg;
   logic [15:0] div_merged;
   logic [15:0] status_word;
   logic        access;
   logic        sel_div;
   logic        push_req;
   logic        status_rd;
   logic        div_wr;
   logic        unused_adr;

   // FIFO
   logic          fifo_pop;
   logic [7:0]    fifo_dout;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;

   // Transmitter
   tx_state_t   state_reg, state_next;
   logic [7:0]  shift_reg, shift_next;
   logic [15:0] cnt_reg, cnt_next;
   logic [2:0]  bit_reg, bit_next;
   logic        tx_reg, tx_next;
   logic [15:0] div_lat_reg, div_lat_next;
`ifdef UART_TX_PARITY_EN
   logic        parity_reg, parity_next;
`endif

   assign unused_adr = ^{wb_adr_i[31:2], wb_adr_i[0]};

   assign access    = wb_cyc_i & wb_stb_i & ~ack_reg;
   assign sel_div   = (wb_adr_i[1] == REG_DIV);
   assign push_req  = access & wb_we_i & ~sel_div & wb_sel_i[0];
   assign status_rd = access & ~wb_we_i & (wb_adr_i[1] == REG_DATA);
   assign div_wr    = access & wb_we_i & sel_div;

   assign wb_ack_o = ack_reg;
   assign wb_dat_o = dat_o_reg;
   assign tx_o     = tx_reg;

   // Each byte lane of the divisor is replaced only when its select is set
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_div_lane
         assign div_merged[gi*8 +: 8] = wb_sel_i[gi] ? wb_dat_i[gi*8 +: 8]
                                                     : div_reg[gi*8 +: 8];
      end
   endgenerate

   // STATUS word assembled from pre-edge state
   always_comb begin
      status_word           = 16'h0000;
      status_word[ST_FULL]  = fifo_full;
      status_word[ST_EMPTY] = fifo_empty;
      status_word[ST_BUSY]  = (state_reg != S_IDLE);
      status_word[ST_OVF]   = ovf_reg;
      status_word[11:8]     = 4'(fifo_count);
   end

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .push  (push_req),
      .din   (wb_dat_i[7:0]),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Single-wait-state slave: ack, read data and side effects share one edge
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ack_reg   <= 1'b0;
         dat_o_reg <= 16'h0000;
         ovf_reg   <= 1'b0;
         div_reg   <= DEFAULT_DIV;
      end else begin
         ack_reg   <= access;
         dat_o_reg <= 16'h0000;
         if (access && !wb_we_i) begin
            dat_o_reg <= sel_div ? div_reg : status_word;
         end
         if (push_req && fifo_full) begin
            ovf_reg <= 1'b1;
         end else if (status_rd) begin
            ovf_reg <= 1'b0;
         end
         if (div_wr) begin
            div_reg <= clamp_div(div_merged);
         end
      end
   end

   // Transmitter state register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg   <= S_IDLE;
         shift_reg   <= 8'h00;
         cnt_reg     <= 16'h0000;
         bit_reg     <= 3'd0;
         tx_reg      <= 1'b1;
         div_lat_reg <= DEFAULT_DIV;
`ifdef UART_TX_PARITY_EN
         parity_reg  <= 1'b0;
`endif
      end else begin
         state_reg   <= state_next;
         shift_reg   <= shift_next;
         cnt_reg     <= cnt_next;
         bit_reg     <= bit_next;
         tx_reg      <= tx_next;
         div_lat_reg <= div_lat_next;
`ifdef UART_TX_PARITY_EN
         parity_reg  <= parity_next;
`endif
      end
   end

   // Next-state and line value: each bit lasts div_lat clocks
   always_comb begin
      state_next   = state_reg;
      shift_next   = shift_reg;
      cnt_next     = cnt_reg;
      bit_next     = bit_reg;
      tx_next      = tx_reg;
      div_lat_next = div_lat_reg;
      fifo_pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_next  = parity_reg;
`endif

      case (state_reg)
         S_IDLE: begin
            tx_next = 1'b1;
         end
         S_START: begin
            if (cnt_reg == 16'd0) begin
               state_next = S_DATA;
               tx_next    = shift_reg[0];
               cnt_next   = div_lat_reg - 16'd1;
               bit_next   = 3'd0;
            end else begin
               cnt_next = cnt_reg - 16'd1;
            end
         end
         S_DATA: begin
            if (cnt_reg == 16'd0) begin
               cnt_next = div_lat_reg - 16'd1;
               if (bit_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_next = S_PARITY;
                  tx_next    = parity_reg;
`else
                  state_next = S_STOP;
                  tx_next    = 1'b1;
`endif
               end else begin
                  shift_next = {1'b0, shift_reg[7:1]};
                  tx_next    = shift_reg[1];
                  bit_next   = bit_reg + 3'd1;
               end
            end else begin
               cnt_next = cnt_reg - 16'd1;
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (cnt_reg == 16'd0) begin
               state_next = S_STOP;
               tx_next    = 1'b1;
               cnt_next   = div_lat_reg - 16'd1;
            end else begin
               cnt_next = cnt_reg - 16'd1;
            end
         end
`endif
         S_STOP: begin
            if (cnt_reg == 16'd0) begin
               state_next = S_IDLE;
               tx_next    = 1'b1;
            end else begin
               cnt_next = cnt_reg - 16'd1;
            end
         end
         default: begin
            state_next = S_IDLE;
            tx_next    = 1'b1;
         end
      endcase

      // A new frame starts from IDLE or directly after the final stop
      // clock, so queued bytes go out with no idle gap between them
      if (!fifo_empty && ((state_reg == S_IDLE) ||
                          ((state_reg == S_STOP) && (cnt_reg == 16'd0)))) begin
         fifo_pop     = 1'b1;
         shift_next   = fifo_dout;
         div_lat_next = div_reg;
         cnt_next     = div_reg - 16'd1;
         tx_next      = 1'b0;
         state_next   = S_START;
`ifdef UART_TX_PARITY_EN
         parity_next  = ^fifo_dout;
`endif
      end
   end

endmodule
